// File: rtl/level_m_mem.sv
// M/W pipeline stage: 2048x32 data RAM with sized loads/stores, address-error detection and W register.
// Optional lwl/lwr/swl/swr support is compiled in with `define LEVEL_M_UNALIGNED_LR_EN.
module level_m_mem (
  input  logic        clk,
  input  logic        reset,
  input  logic        InterruptRequest,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  WriteRegM,
  input  logic [1:0]  MemTypeM,
  input  logic        LoadExtSignM,
  input  logic        LeftRightM,
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  input  logic        RegWriteM,
  input  logic [31:0] PCM,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [31:0] PCW,
  output logic [4:0]  WriteRegW,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic        ErrorAdelM,
  output logic        ErrorAdesM
);
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;
  localparam int DEPTH     = 2048;

  typedef enum logic [1:0] {MT_WORD = 2'b00, MT_HALF = 2'b01, MT_BYTE = 2'b10, MT_LR = 2'b11} mem_type_e;

  logic [NUM_LANES-1:0][LANE_W-1:0] mem_q [DEPTH];

  mem_type_e   mt;
  logic [10:0] widx;
  logic [1:0]  k;
  logic [NUM_LANES-1:0][LANE_W-1:0] rlanes;
  logic [31:0] rword;
  logic [15:0] half_v;
  logic [7:0]  byte_v;
  logic        out_of_range, misalign, addr_bad;

  assign mt     = mem_type_e'(MemTypeM);
  assign widx   = ALUOutM[12:2];
  assign k      = ALUOutM[1:0];
  assign rlanes = mem_q[widx];
  assign rword  = rlanes;
  assign half_v = k[1] ? rword[31:16] : rword[15:0];
  assign byte_v = rlanes[k];

`ifdef LEVEL_M_UNALIGNED_LR_EN
  // Left ops align byte k of memory with byte 3 of rt; right ops align byte k with byte 0.
  logic [4:0] sh_l, sh_r;
  assign sh_l = {~k, 3'b000};
  assign sh_r = {k, 3'b000};
`else
  logic unused_lr;
  assign unused_lr = LeftRightM;
`endif

  always_comb begin
    out_of_range = |ALUOutM[31:13];
    misalign     = 1'b0;
    case (mt)
      MT_WORD: misalign = |k;
      MT_HALF: misalign = k[0];
`ifdef LEVEL_M_UNALIGNED_LR_EN
      MT_LR:   misalign = 1'b0;
`else
      MT_LR:   misalign = 1'b1;
`endif
      default: misalign = 1'b0;
    endcase
    addr_bad = out_of_range | misalign;
  end

  assign ErrorAdelM = MemtoRegM & addr_bad;
  assign ErrorAdesM = MemWriteM & addr_bad;

  logic [31:0] load_data;
  always_comb begin
    load_data = rword;
    case (mt)
      MT_HALF: load_data = {{16{LoadExtSignM & half_v[15]}}, half_v};
      MT_BYTE: load_data = {{24{LoadExtSignM & byte_v[7]}}, byte_v};
`ifdef LEVEL_M_UNALIGNED_LR_EN
      MT_LR: begin
        if (LeftRightM) load_data = (rword << sh_l) | (WriteDataM & ~(32'hFFFF_FFFF << sh_l));
        else            load_data = (rword >> sh_r) | (WriteDataM & ~(32'hFFFF_FFFF >> sh_r));
      end
`else
      MT_LR:   load_data = '0;
`endif
      default: load_data = rword;
    endcase
  end

  logic [NUM_LANES-1:0]             st_be;
  logic [NUM_LANES-1:0][LANE_W-1:0] st_lanes;
  logic                             st_en;
  always_comb begin
    st_be    = '1;
    st_lanes = WriteDataM;
    case (mt)
      MT_HALF: begin
        st_be    = k[1] ? 4'b1100 : 4'b0011;
        st_lanes = {2{WriteDataM[15:0]}};
      end
      MT_BYTE: begin
        st_be    = 4'b0001 << k;
        st_lanes = {4{WriteDataM[7:0]}};
      end
`ifdef LEVEL_M_UNALIGNED_LR_EN
      MT_LR: begin
        if (LeftRightM) begin
          st_be    = 4'b1111 >> ~k;
          st_lanes = WriteDataM >> sh_l;
        end else begin
          st_be    = 4'b1111 << k;
          st_lanes = WriteDataM << sh_r;
        end
      end
`else
      MT_LR:   st_be = '0;
`endif
      default: st_be = '1;
    endcase
    st_en = MemWriteM & ~ErrorAdesM & ~InterruptRequest & ~reset;
  end

  // RAM is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (st_en) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (st_be[i]) mem_q[widx][i] <= st_lanes[i];
      end
    end
  end

  logic [31:0] read_data_d, read_data_q, alu_out_d, alu_out_q, pc_d, pc_q;
  logic [4:0]  write_reg_d, write_reg_q;
  logic        reg_write_d, reg_write_q, memto_reg_d, memto_reg_q;

  always_comb begin
    read_data_d = (MemtoRegM & ~ErrorAdelM) ? load_data : '0;
    alu_out_d   = ALUOutM;
    pc_d        = PCM;
    write_reg_d = WriteRegM;
    reg_write_d = RegWriteM & ~ErrorAdelM;
    memto_reg_d = MemtoRegM;
    if (InterruptRequest) begin
      read_data_d = '0;
      alu_out_d   = '0;
      pc_d        = '0;
      write_reg_d = '0;
      reg_write_d = 1'b0;
      memto_reg_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_q <= '0;
      alu_out_q   <= '0;
      pc_q        <= '0;
      write_reg_q <= '0;
      reg_write_q <= 1'b0;
      memto_reg_q <= 1'b0;
    end else begin
      read_data_q <= read_data_d;
      alu_out_q   <= alu_out_d;
      pc_q        <= pc_d;
      write_reg_q <= write_reg_d;
      reg_write_q <= reg_write_d;
      memto_reg_q <= memto_reg_d;
    end
  end

  assign ReadDataW = read_data_q;
  assign ALUOutW   = alu_out_q;
  assign PCW       = pc_q;
  assign WriteRegW = write_reg_q;
  assign RegWriteW = reg_write_q;
  assign MemtoRegW = memto_reg_q;
endmodule

// File: doc/level_m_mem.md
LEVEL_M_MEM -- requirements
Module: level_m_mem

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port InterruptRequest  input  1  flush: squash this cycle's store and bubble the M/W register.
REQ-004 SHALL have port ALUOutM  input  32  effective address, or ALU result to pass through.
REQ-005 SHALL have port WriteDataM  input  32  store data.
REQ-006 SHALL have port WriteRegM  input  5  destination register.
REQ-007 SHALL have port MemTypeM  input  2  access size: 00 word, 01 half, 10 byte, 11 unaligned-LR.
REQ-008 SHALL have ports LoadExtSignM, LeftRightM, MemWriteM, MemtoRegM, RegWriteM  input  1 each  load sign-extend, LR select (1=left), store enable, load select, register write.
REQ-009 SHALL have port PCM  input  32  PC of the M-stage instruction.
REQ-010 SHALL have outputs ReadDataW, ALUOutW, PCW (32 each); WriteRegW (5); RegWriteW, MemtoRegW (1 each)  registered W-stage values.
REQ-011 SHALL have outputs ErrorAdelM, ErrorAdesM  output  1 each  combinational load/store address error for the current M instruction.

Function
REQ-012 SHALL contain 2048x32 data RAM at byte addresses 0x0000_0000-0x0000_1FFF; word index = ALUOutM[12:2].
REQ-013 SHALL use combinational RAM read; the aligned/extended load result SHALL be captured into ReadDataW at the next edge (1-cycle latency).
REQ-014 SHALL perform stores at the rising edge only when MemWriteM=1, ErrorAdesM=0, InterruptRequest=0 and reset=0.
REQ-015 Byte stores SHALL write lane ALUOutM[1:0] from WriteDataM[7:0]; half stores SHALL write lanes {ALUOutM[1],x} from WriteDataM[15:0]; other lanes SHALL remain unchanged.
REQ-016 Loads SHALL select the same lane and zero-extend, or sign-extend when LoadExtSignM=1; word loads SHALL return the whole word.
REQ-017 ErrorAdelM SHALL be 1 when MemtoRegM=1 and either (word and ALUOutM[1:0]!=0), (half and ALUOutM[0]=1), or ALUOutM>=0x2000.
REQ-018 ErrorAdesM SHALL use the same conditions with MemWriteM=1.
REQ-019 A load with ErrorAdelM=1 SHALL register RegWriteW=0 and ReadDataW=0.
REQ-020 When InterruptRequest=1, the next-cycle W outputs SHALL all be 0 (bubble).
REQ-021 Back-to-back store then load to the same word SHALL return the newly stored data, because the write completes at the edge before the load reads.

Reset
REQ-022 When reset=1 at an edge, every W output SHALL become 0 and no RAM write SHALL occur; reset SHALL override InterruptRequest.
REQ-023 RAM contents SHALL NOT be cleared by reset.
REQ-024 Reset asserted mid-sequence SHALL discard any in-flight M instruction with no partial write.

Configuration
REQ-025 Macro LEVEL_M_UNALIGNED_LR_EN SHALL gate lwl/lwr/swl/swr support (MemTypeM=11).
REQ-026 With LEVEL_M_UNALIGNED_LR_EN defined:
- A left load SHALL merge the memory bytes [k:0] into the upper bytes of WriteDataM (old rt), where k=ALUOutM[1:0].
- A right load SHALL merge the memory bytes [3:k] into the lower bytes.
- Stores SHALL mirror these merges.
- No alignment error SHALL be raised for these accesses.
REQ-027 Without LEVEL_M_UNALIGNED_LR_EN, MemTypeM=11 SHALL be treated as an address error (ErrorAdelM/ErrorAdesM per REQ-017/018) and SHALL never write RAM.

Verification
REQ-028 sw 0x11223344 @0x10, then lw @0x10 -> ReadDataW=0x11223344 one cycle after the load.
REQ-029 sb 0xAB @0x13, then lb @0x13 (sign) -> 0xFFFFFFAB; lbu -> 0x000000AB; word @0x10 -> 0xAB223344.
REQ-030 lw @0x12 -> ErrorAdelM=1, RegWriteW=0; sh @0x2000 -> ErrorAdesM=1 and the RAM is unchanged.
REQ-031 sw with InterruptRequest=1 -> the RAM is unchanged and the next-cycle W outputs are all 0.
REQ-032 reset during an sw -> no write occurs and all W outputs are 0; RAM contents from before the reset are preserved.
REQ-033 With LEVEL_M_UNALIGNED_LR_EN, mem 0x11223344, rt=0xAABBCCDD, lwl @addr[1:0]=1 -> 0x3344CCDD; without the macro -> ErrorAdelM=1.
